pipelined_csel_adder: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor. Successor to the fixed 6-bit combinational carry-select adder.
- Operands are split into NSEG = WIDTH/SEG segments. Pipeline stage k resolves segment k by selecting between precomputed carry-0 and carry-1 sums.
- Valid/ready handshake on both sides. Throughput is one operation per cycle. Sits on the datapath feeding the ALU result bus.

---
 rtl/csel_pkg.sv | 40 ++++
 rtl/csel_segment.sv | 43 ++++
 rtl/pipelined_csel_adder.sv | 118 +++++++++++
 tb/tb_pipelined_csel_adder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csel_pkg.sv
// Shared types and helpers for the pipelined carry-select adder.
// Widths are capped at CSEL_MAX_W so the stage payload can live in the package.
package csel_pkg;

  localparam int CSEL_MAX_W = 64;

  typedef struct packed {
    logic                  carry;
    logic [CSEL_MAX_W-1:0] sum;
  } cand_t;

  typedef struct packed {
    logic [CSEL_MAX_W-1:0] sum;   // low bits resolved so far
    logic                  carry; // carry into the next unresolved segment
    logic [CSEL_MAX_W-1:0] a;
    logic [CSEL_MAX_W-1:0] b;     // already inverted for subtraction
  } stage_t;

  function automatic int nseg_of(input int width, input int seg);
    return width / seg;
  endfunction

  // Sum of the low 'seg' bits of x and y plus cin; carry is the bit just above the segment.
  function automatic cand_t seg_sum(input logic [CSEL_MAX_W-1:0] x,
                                    input logic [CSEL_MAX_W-1:0] y,
                                    input logic                  cin,
                                    input int                    seg);
    logic [CSEL_MAX_W:0] one_s;
    logic [CSEL_MAX_W:0] mask_s;
    logic [CSEL_MAX_W:0] full_s;
    cand_t               res_s;
    one_s       = {{CSEL_MAX_W{1'b0}}, 1'b1};
    mask_s      = (one_s << seg) - one_s;
    full_s      = ({1'b0, x} & mask_s) + ({1'b0, y} & mask_s) + {{CSEL_MAX_W{1'b0}}, cin};
    res_s.carry = |(full_s & ~mask_s);
    res_s.sum   = full_s[CSEL_MAX_W-1:0] & mask_s[CSEL_MAX_W-1:0];
    return res_s;
  endfunction

endpackage

// File: rtl/csel_segment.sv
// Combinational SEG-bit carry-select cell: both carry-in candidates side by side.
module csel_segment
  import csel_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  output logic [SEG-1:0] s0,
  output logic           c0,
  output logic [SEG-1:0] s1,
  output logic           c1
);

  if (SEG < 1 || SEG >= CSEL_MAX_W) begin : g_bad_seg
    $error("csel_segment: SEG out of range");
  end

  logic [CSEL_MAX_W-1:0] a_ext_s;
  logic [CSEL_MAX_W-1:0] b_ext_s;
  cand_t                 cand0_s;
  cand_t                 cand1_s;
  logic                  unused_hi_s;

  // Widen the segment and evaluate the carry-0 and carry-1 candidates.
  always_comb begin
    a_ext_s          = '0;
    b_ext_s          = '0;
    a_ext_s[SEG-1:0] = a_seg;
    b_ext_s[SEG-1:0] = b_seg;
    cand0_s          = seg_sum(a_ext_s, b_ext_s, 1'b0, SEG);
    cand1_s          = seg_sum(a_ext_s, b_ext_s, 1'b1, SEG);
  end

  assign s0 = cand0_s.sum[SEG-1:0];
  assign c0 = cand0_s.carry;
  assign s1 = cand1_s.sum[SEG-1:0];
  assign c1 = cand1_s.carry;

  // Bits above the segment are always zero from the helper.
  assign unused_hi_s = ^{cand0_s.sum[CSEL_MAX_W-1:SEG], cand1_s.sum[CSEL_MAX_W-1:SEG]};

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: stage k resolves segment k, valid/ready on both sides.
// Results leave in order; an elastic ready chain lets bubbles collapse and holds NSEG beats under stall.
module pipelined_csel_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = nseg_of(WIDTH, SEG);

  if (SEG < 1 || WIDTH < SEG || WIDTH > CSEL_MAX_W || (WIDTH % SEG) != 0) begin : g_bad_params
    $error("pipelined_csel_adder: WIDTH must be a multiple of SEG and at most CSEL_MAX_W");
  end

  stage_t          stage_r [NSEG];
  logic [NSEG-1:0] valid_r;
  logic [NSEG:0]   ready_s;
  logic            ovf_r;

  // Backward ready chain: a stage may load when it is empty or its successor is loading.
  always_comb begin
    ready_s       = '0;
    ready_s[NSEG] = out_ready;
    for (int i = NSEG - 1; i >= 0; i--) begin
      ready_s[i] = !valid_r[i] || ready_s[i+1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    stage_t         prev_s;
    stage_t         next_s;
    logic           prev_valid_s;
    logic [SEG-1:0] s0_s;
    logic [SEG-1:0] s1_s;
    logic           c0_s;
    logic           c1_s;

    if (k == 0) begin : g_prep
      // Subtraction is folded in here as A + ~B + 1, so later stages only add.
      always_comb begin
        prev_s              = '0;
        prev_s.a[WIDTH-1:0] = a;
        prev_s.b[WIDTH-1:0] = sub ? ~b : b;
        prev_s.carry        = sub ? 1'b1 : cin;
      end
      assign prev_valid_s = in_valid;
    end else begin : g_chain
      assign prev_s       = stage_r[k-1];
      assign prev_valid_s = valid_r[k-1];
    end

    csel_segment #(.SEG(SEG)) u_seg (
      .a_seg (prev_s.a[k*SEG +: SEG]),
      .b_seg (prev_s.b[k*SEG +: SEG]),
      .s0    (s0_s),
      .c0    (c0_s),
      .s1    (s1_s),
      .c1    (c1_s)
    );

    // Pick the candidate matching the carry handed down by the previous stage.
    always_comb begin
      next_s                   = prev_s;
      next_s.sum[k*SEG +: SEG] = prev_s.carry ? s1_s : s0_s;
      next_s.carry             = prev_s.carry ? c1_s : c0_s;
    end

    // Stage register; payload only moves with a valid beat so a stalled output holds still.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_r[k] <= 1'b0;
        stage_r[k] <= '0;
      end else if (ready_s[k]) begin
        valid_r[k] <= prev_valid_s;
        if (prev_valid_s) begin
          stage_r[k] <= next_s;
        end
      end
    end

    if (k == NSEG - 1) begin : g_ovf
      logic msb_cin_s;
      // Carry into the MSB recovered from its sum bit and operand bits.
      assign msb_cin_s = next_s.sum[WIDTH-1] ^ prev_s.a[WIDTH-1] ^ prev_s.b[WIDTH-1];

      // Overflow flag loads in lockstep with the final stage register.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (ready_s[k] && prev_valid_s) begin
          ovf_r <= msb_cin_s ^ next_s.carry;
        end
      end
    end
  end

  assign in_ready  = ready_s[0];
  assign out_valid = valid_r[NSEG-1];
  assign sum       = stage_r[NSEG-1].sum[WIDTH-1:0];
  assign cout      = stage_r[NSEG-1].carry;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Scoreboard bench for pipelined_csel_adder (WIDTH=16, SEG=4): directed, stall, full-rate and reset scenarios.
module tb_pipelined_csel_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic        acc;
    logic        emit;
    logic        ov;
    logic        ir;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  pipelined_csel_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic s);
    logic [15:0] ye;
    logic [16:0] t;
    exp_t        e;
    ye        = s ? ~y : y;
    t         = {1'b0, x} + {1'b0, ye} + {16'd0, (s ? 1'b1 : ci)};
    e.sum     = t[15:0];
    e.cout    = t[16];
    e.ovf     = (x[15] == ye[15]) && (t[15] != x[15]);
    e.acc_cyc = 0;
    return e;
  endfunction

  // One clock: drive inputs after the falling edge, observe, push expected on accept.
  task automatic drive_cycle(input logic v, input logic [15:0] ai, input logic [15:0] bi,
                             input logic ci, input logic si, input logic ro,
                             input exp_t e, output obs_t o);
    in_valid = v; a = ai; b = bi; cin = ci; sub = si; out_ready = ro;
    #1;
    o.acc  = in_valid && in_ready;
    o.emit = out_valid && out_ready;
    o.ov   = out_valid;
    o.ir   = in_ready;
    o.sum  = sum;
    o.cout = cout;
    o.ovf  = ovf;
    o.cyc  = cyc;
    if (o.acc) begin
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t o;
    exp_t e = '{16'h0000, 1'b0, 1'b0, 0};
    rst = 1'b1;
    drive_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, e, o);
    drive_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, e, o);
    rst = 1'b0;
    drive_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, e, o);
    n_cmp++; if (o.ov !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", o.ov); end
    n_cmp++; if (o.ir !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", o.ir); end
    n_cmp++; if (o.sum !== 16'h0000) begin n_bad++; $display("FAIL reset_sum: got %h want 0000", o.sum); end
    n_cmp++; if (o.cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b want 0", o.cout); end
    n_cmp++; if (o.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", o.ovf); end
  endtask

  task automatic test_add();
    vec_t vt[3];
    obs_t o;
    exp_t e = '{16'h0000, 1'b0, 1'b0, 0};
    exp_t got;
    int   idx = 0;
    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[2] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
    for (int c = 0; c < 20; c++) begin
      if (idx < 3) begin
        e = '{vt[idx].sum, vt[idx].cout, vt[idx].ovf, 0};
        drive_cycle(1'b1, vt[idx].a, vt[idx].b, vt[idx].cin, vt[idx].sub, 1'b1, e, o);
        if (o.acc) idx++;
      end else begin
        drive_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, e, o);
      end
      if (o.emit) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL add_spurious: got sum=%h with nothing outstanding", o.sum);
        end else begin
          got = sb.pop_front();
          n_cmp++;
          if ({o.sum, o.cout, o.ovf} !== {got.sum, got.cout, got.ovf}) begin
            n_bad++;
            $display("FAIL add_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     o.sum, o.cout, o.ovf, got.sum, got.cout, got.ovf);
          end
          n_cmp++;
          if (o.cyc - got.acc_cyc != 4) begin
            n_bad++; $display("FAIL add_latency: got %0d want 4", o.cyc - got.acc_cyc);
          end
        end
      end
      if (idx == 3 && sb.size() == 0) break;
    end
    n_cmp++;
    if (idx != 3 || sb.size() != 0) begin
      n_bad++; $display("FAIL add_drain: sent %0d outstanding %0d want 3/0", idx, sb.size());
    end
  endtask

  task automatic test_sub();
    vec_t vt[2];
    obs_t o;
    exp_t e = '{16'h0000, 1'b0, 1'b0, 0};
    exp_t got;
    int   idx = 0;
    vt[0] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    for (int c = 0; c < 20; c++) begin
      if (idx < 2) begin
        e = '{vt[idx].sum, vt[idx].cout, vt[idx].ovf, 0};
        drive_cycle(1'b1, vt[idx].a, vt[idx].b, vt[idx].cin, vt[idx].sub, 1'b1, e, o);
        if (o.acc) idx++;
      end else begin
        drive_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, e, o);
      end
      if (o.emit) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL sub_spurious: got sum=%h with nothing outstanding", o.sum);
        end else begin
          got = sb.pop_front();
          n_cmp++;
          if ({o.sum, o.cout, o.ovf} !== {got.sum, got.cout, got.ovf}) begin
            n_bad++;
            $display("FAIL sub_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     o.sum, o.cout, o.ovf, got.sum, got.cout, got.ovf);
          end
        end
      end
      if (idx == 2 && sb.size() == 0) break;
    end
    n_cmp++;
    if (idx != 2 || sb.size() != 0) begin
      n_bad++; $display("FAIL sub_drain: sent %0d outstanding %0d want 2/0", idx, sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] va[10], vb[10];
    logic        vs[10];
    obs_t        o;
    exp_t        e, got;
    logic        ro, vnow;
    logic        fell = 1'b0;
    int          idx = 0;
    int          emitted = 0;
    for (int i = 0; i < 10; i++) begin
      va[i] = 16'(i) * 16'h1357 + 16'h0101;
      vb[i] = ~(16'(i) * 16'h0321);
      vs[i] = i[0];
    end
    for (int c = 0; c < 80; c++) begin
      ro   = (c < 3 || c > 9);
      vnow = (idx < 10);
      if (vnow) begin
        e = model(va[idx], vb[idx], 1'b0, vs[idx]);
        drive_cycle(1'b1, va[idx], vb[idx], 1'b0, vs[idx], ro, e, o);
        if (o.acc) idx++;
      end else begin
        drive_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, ro, e, o);
      end
      if (vnow && !o.ir && !fell) begin
        fell = 1'b1;
        n_cmp++;
        if (sb.size() != 4) begin n_bad++; $display("FAIL bp_depth: in_ready fell with %0d held want 4", sb.size()); end
      end
      if (o.ov && !ro) begin
        n_cmp++;
        if (sb.size() == 0 || o.sum !== sb[0].sum || o.cout !== sb[0].cout || o.ovf !== sb[0].ovf) begin
          n_bad++; $display("FAIL bp_stall_hold: got sum=%h cycle %0d not the pending head", o.sum, c);
        end
      end
      if (o.emit) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL bp_spurious: got sum=%h with nothing outstanding", o.sum);
        end else begin
          got = sb.pop_front();
          emitted++;
          n_cmp++;
          if ({o.sum, o.cout, o.ovf} !== {got.sum, got.cout, got.ovf}) begin
            n_bad++;
            $display("FAIL bp_result: beat %0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     emitted, o.sum, o.cout, o.ovf, got.sum, got.cout, got.ovf);
          end
        end
      end
      if (idx == 10 && sb.size() == 0) break;
    end
    n_cmp++; if (!fell) begin n_bad++; $display("FAIL bp_in_ready: got never low want low while full"); end
    n_cmp++; if (emitted != 10) begin n_bad++; $display("FAIL bp_count: got %0d results want 10", emitted); end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL bp_drain: got %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    obs_t        o;
    exp_t        e, got;
    logic [15:0] ca, cb;
    logic        cc, cs, vnow;
    int          idx = 0;
    int          last_emit = -1;
    ca = 16'($urandom); cb = 16'($urandom); cc = 1'($urandom); cs = 1'($urandom);
    for (int c = 0; c < 40; c++) begin
      vnow = (idx < 12);
      if (vnow) begin
        e = model(ca, cb, cc, cs);
        drive_cycle(1'b1, ca, cb, cc, cs, 1'b1, e, o);
        n_cmp++;
        if (!o.acc) begin n_bad++; $display("FAIL b2b_accept: got in_ready=%b want 1 at beat %0d", o.ir, idx); end
        if (o.acc) begin
          idx++;
          ca = 16'($urandom); cb = 16'($urandom); cc = 1'($urandom); cs = 1'($urandom);
        end
      end else begin
        drive_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, e, o);
      end
      if (o.emit) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL b2b_spurious: got sum=%h with nothing outstanding", o.sum);
        end else begin
          got = sb.pop_front();
          n_cmp++;
          if ({o.sum, o.cout, o.ovf} !== {got.sum, got.cout, got.ovf}) begin
            n_bad++;
            $display("FAIL b2b_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     o.sum, o.cout, o.ovf, got.sum, got.cout, got.ovf);
          end
          n_cmp++;
          if (o.cyc - got.acc_cyc != 4) begin
            n_bad++; $display("FAIL b2b_latency: got %0d want 4", o.cyc - got.acc_cyc);
          end
          if (last_emit >= 0) begin
            n_cmp++;
            if (o.cyc - last_emit != 1) begin n_bad++; $display("FAIL b2b_gap: got %0d want 1", o.cyc - last_emit); end
          end
          last_emit = o.cyc;
        end
      end
      if (idx == 12 && sb.size() == 0) break;
    end
    n_cmp++;
    if (idx != 12 || sb.size() != 0) begin
      n_bad++; $display("FAIL b2b_drain: sent %0d outstanding %0d want 12/0", idx, sb.size());
    end
  endtask

  task automatic test_reset_inflight();
    logic [15:0] va[3], vb[3];
    obs_t        o;
    exp_t        e, got;
    logic        sent = 1'b0;
    logic        seen = 1'b0;
    va[0] = 16'h1234; vb[0] = 16'h1111;
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF;
    va[2] = 16'hA5A5; vb[2] = 16'h5A5A;
    for (int i = 0; i < 3; i++) begin
      e = model(va[i], vb[i], 1'b1, 1'b0);
      drive_cycle(1'b1, va[i], vb[i], 1'b1, 1'b0, 1'b1, e, o);
      n_cmp++;
      if (!o.acc) begin n_bad++; $display("FAIL rst_fill: got in_ready=%b want 1 at beat %0d", o.ir, i); end
    end
    rst = 1'b1;
    drive_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, e, o);
    rst = 1'b0;
    sb.delete();
    drive_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, e, o);
    n_cmp++; if (o.ov !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", o.ov); end
    n_cmp++; if (o.sum !== 16'h0000) begin n_bad++; $display("FAIL rst_sum: got %h want 0000", o.sum); end
    n_cmp++; if (o.ir !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", o.ir); end
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, e, o);
      n_cmp++;
      if (o.ov !== 1'b0) begin n_bad++; $display("FAIL rst_ghost: got out_valid=%b sum=%h want no result", o.ov, o.sum); end
    end
    for (int c = 0; c < 12; c++) begin
      if (!sent) begin
        e = model(16'h00FF, 16'h0001, 1'b0, 1'b0);
        drive_cycle(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, e, o);
        if (o.acc) sent = 1'b1;
      end else begin
        drive_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, e, o);
      end
      if (o.emit && sb.size() != 0) begin
        got  = sb.pop_front();
        seen = 1'b1;
        n_cmp++;
        if (o.sum !== 16'h0100 || o.cout !== 1'b0 || o.ovf !== 1'b0) begin
          n_bad++; $display("FAIL rst_fresh: got sum=%h cout=%b ovf=%b want 0100/0/0", o.sum, o.cout, o.ovf);
        end
        n_cmp++;
        if (o.cyc - got.acc_cyc != 4) begin n_bad++; $display("FAIL rst_fresh_latency: got %0d want 4", o.cyc - got.acc_cyc); end
      end
      if (seen) break;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rst_fresh_timeout: got no result want one within budget"); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
